// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer.
// Contents: opcode/funct3 values, the FSM state type, mux-select and ALU encodings,
// the instruction class vector and the Moore output bundle with its per-state decode.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  // One-hot instruction class; exactly one bit is set for any opcode/funct3.
  typedef struct packed {
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic jal;
    logic illegal;
  } iclass_t;

  // Outputs that depend on the state alone; handshake-qualified terms are added in the top.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       pc_write;
    logic       retire;
    logic       trap;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
  } moore_t;

  function automatic moore_t moore_outputs(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_req    = 1'b1;
        m.src_a      = SRCA_PC;
        m.src_b      = SRCB_FOUR;
        m.alu_ctrl   = ALU_ADD;
        m.result_src = RES_ALU;
      end
      S_DECODE: begin
        m.src_a = SRCA_OLDPC;
        m.src_b = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        m.src_a = SRCA_RS1;
        m.src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        m.mem_req = 1'b1;
        m.adr_src = 1'b1;
      end
      S_MEMWB: begin
        m.result_src = RES_MEM;
        m.reg_write  = 1'b1;
        m.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        m.mem_req   = 1'b1;
        m.mem_write = 1'b1;
        m.adr_src   = 1'b1;
      end
      S_ALUWB: begin
        m.result_src = RES_ALUOUT;
        m.reg_write  = 1'b1;
        m.retire     = 1'b1;
      end
      S_BRANCH: begin
        m.src_a      = SRCA_RS1;
        m.src_b      = SRCB_RS2;
        m.alu_ctrl   = ALU_SUB;
        m.result_src = RES_ALUOUT;
        m.retire     = 1'b1;
      end
      S_JAL: begin
        m.src_a      = SRCA_OLDPC;
        m.src_b      = SRCB_FOUR;
        m.result_src = RES_ALUOUT;
        m.pc_write   = 1'b1;
      end
      S_HALT: m.trap = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the sequencer and the datapath/memory side.
// master: the controller (drives strobes and selects, receives instr, EQ, mem_ready).
// slave : the datapath/memory side (drives instr, EQ, mem_ready).
interface multicycle_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] instr;
  logic                  EQ;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  MemWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  RegWrite;
  logic [1:0]            ALUsrcA;
  logic [1:0]            ALUsrcB;
  logic [2:0]            ALUctrl;
  logic [1:0]            ResultSrc;
  logic [2:0]            ImmSrc;
  logic                  retire;
  logic                  trap;

  modport master (
    input  instr, EQ, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUsrcA, ALUsrcB, ALUctrl, ResultSrc, ImmSrc, retire, trap
  );

  modport slave (
    output instr, EQ, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUsrcA, ALUsrcB, ALUctrl, ResultSrc, ImmSrc, retire, trap
  );
endinterface

// File: rtl/multicycle_ctrl_instr_class.sv
// Combinational instruction classifier.
// Ports: opcode (instr[6:0]), funct3 (instr[14:12]) in;
//        cls (one-hot class incl. illegal) and imm_src (immediate format) out.
module multicycle_ctrl_instr_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_t    cls,
  output logic [2:0] imm_src
);

  always_comb begin
    cls         = '0;
    cls.addi    = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
    cls.lw      = (opcode == OP_LOAD)   && (funct3 == F3_WORD);
    cls.sw      = (opcode == OP_STORE)  && (funct3 == F3_WORD);
    cls.beq     = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
    cls.bne     = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
    cls.jal     = (opcode == OP_JAL);
    cls.illegal = !(cls.addi || cls.lw || cls.sw || cls.beq || cls.bne || cls.jal);
  end

  // Format follows the opcode only, so it is valid in every state.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_IMM, OP_LOAD: imm_src = IMM_I;
      OP_BRANCH:       imm_src = IMM_B;
      OP_STORE:        imm_src = IMM_S;
      OP_JAL:          imm_src = IMM_J;
      default:         imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core (addi, lw, sw, beq, bne, jal).
// Ports: clk, rst (async, active-high); bus (multicycle_ctrl_if.master) carrying
//        instr/EQ/mem_ready in and all mux selects, write strobes, retire and trap out.
// Optional feature: define ILLEGAL_TRAP_EN to halt on an illegal instruction (trap=1
// until rst); otherwise an illegal instruction retires as a NOP.
//
// state      | meaning
// FETCH      | request instr at PC, PC+4 on result bus; IR/PC load on mem_ready
// DECODE     | oldPC+imm into ALUOut (branch/jal target)
// MEMADR     | rs1+imm into ALUOut
// MEMREAD    | load request at ALUOut, wait mem_ready
// MEMWB      | write MemData to rd, retire
// MEMWRITE   | store request at ALUOut, retire on mem_ready
// EXECI      | rs1+imm into ALUOut
// ALUWB      | write ALUOut to rd, retire
// BRANCH     | rs1-rs2, PC <- target if taken, retire
// JAL        | PC <- target, oldPC+4 into ALUOut
// HALT       | illegal instruction trap (ILLEGAL_TRAP_EN only)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  state_t     state;
  state_t     nxt;
  moore_t     mo;
  iclass_t    cls;
  logic [2:0] imm_src;
  logic       br_taken;

  multicycle_ctrl_instr_class u_class (
    .opcode  (bus.instr[6:0]),
    .funct3  (bus.instr[14:12]),
    .cls     (cls),
    .imm_src (imm_src)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (cls.lw || cls.sw)        nxt = S_MEMADR;
        else if (cls.addi)           nxt = S_EXECI;
        else if (cls.beq || cls.bne) nxt = S_BRANCH;
        else if (cls.jal)            nxt = S_JAL;
`ifdef ILLEGAL_TRAP_EN
        else                         nxt = S_HALT;
`else
        else                         nxt = S_FETCH;
`endif
      end
      S_MEMADR:   nxt = cls.lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      mo    <= moore_outputs(S_FETCH);
    end else begin
      state <= nxt;
      mo    <= moore_outputs(nxt);
    end
  end

  assign br_taken = (cls.beq && bus.EQ) || (cls.bne && !bus.EQ);

  // rst masks everything, so the FETCH request held in mo during reset only
  // appears once rst is released.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUsrcA   = 2'b00;
    bus.ALUsrcB   = 2'b00;
    bus.ALUctrl   = 3'b000;
    bus.ResultSrc = 2'b00;
    bus.ImmSrc    = 3'b000;
    bus.retire    = 1'b0;
    bus.trap      = 1'b0;
    if (!rst) begin
      bus.mem_req   = mo.mem_req;
      bus.MemWrite  = mo.mem_write;
      bus.AdrSrc    = mo.adr_src;
      bus.RegWrite  = mo.reg_write;
      bus.ALUsrcA   = mo.src_a;
      bus.ALUsrcB   = mo.src_b;
      bus.ALUctrl   = mo.alu_ctrl;
      bus.ResultSrc = mo.result_src;
      bus.ImmSrc    = imm_src;
      bus.IRWrite   = (state == S_FETCH) && bus.mem_ready;
      bus.PCWrite   = mo.pc_write
                    || ((state == S_FETCH) && bus.mem_ready)
                    || ((state == S_BRANCH) && br_taken);
      bus.retire    = mo.retire
                    || ((state == S_MEMWRITE) && bus.mem_ready)
`ifndef ILLEGAL_TRAP_EN
                    || ((state == S_DECODE) && cls.illegal)
`endif
                    ;
`ifdef ILLEGAL_TRAP_EN
      bus.trap      = mo.trap;
`endif
    end
  end

endmodule
